// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, FSM encodings, bench cycle time and PC helper.
// The wrap option for the top level is selected with the FETCH_WRAP_EN macro.
`ifndef FETCH_DEFINITIONS_VH
`define FETCH_DEFINITIONS_VH
`define WORD 32
`define FS_IDLE 2'd0
`define FS_RUN 2'd1
`define FS_FLUSH 2'd2
`define FS_DONE 2'd3
`define CYCLE 10
`endif

package fetch_unit_pkg;

  localparam int WORD_W = `WORD;
  localparam int ENTRY_W = 2 * WORD_W;

  localparam logic [1:0] ST_IDLE = `FS_IDLE;
  localparam logic [1:0] ST_RUN = `FS_RUN;
  localparam logic [1:0] ST_FLUSH = `FS_FLUSH;
  localparam logic [1:0] ST_DONE = `FS_DONE;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // At the last word either wrap to 0 or hold there, depending on the build.
  function automatic logic [WORD_W-1:0] pc_advance(
    input logic [WORD_W-1:0] cur,
    input logic [WORD_W-1:0] last,
    input logic wrap
  );
    logic [WORD_W-1:0] nxt;
    nxt = cur + 1'b1;
    if (cur == last) begin
      nxt = wrap ? '0 : cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Two-entry {pc, instr} FIFO between instruction fetch and decode; clear wins over push/pop.
import fetch_unit_pkg::*;

module fetch_buffer (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               clear,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head,
  output logic               valid
);

  logic [ENTRY_W-1:0] entry [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A full buffer may still accept a push when its head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else if (clear) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid = (count != 2'd0);
  assign head  = valid ? entry[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: PC, one in-flight request tag, FSM, redirect and end-of-memory stop.
// Define FETCH_WRAP_EN to wrap the PC at the end of memory instead of stopping in DONE.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted
);

`ifdef FETCH_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  localparam logic [WORD_W-1:0] LAST_PC = 32'(MEM_DEPTH - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               req_v;
  logic [WORD_W-1:0]  req_pc;
  logic               redirect;
  logic               issue_state;
  logic               issue;
  logic               last_issue;
  logic [2:0]         occupancy;

  logic               buf_push;
  logic               buf_pop;
  logic               buf_clear;
  logic [1:0]         buf_count;
  logic               buf_valid;
  logic [ENTRY_W-1:0] buf_head;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;

  assign redirect    = redirect_valid && (state != ST_IDLE);
  assign buf_pop     = buf_valid && if_ready;
  // Buffered entries after this cycle's pop, plus the response still in flight.
  assign occupancy   = {1'b0, buf_count} + {2'b00, req_v} - {2'b00, buf_pop};
  assign issue_state = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_FLUSH);
  assign issue       = en && issue_state && !redirect && (occupancy < 3'd2);
  assign last_issue  = issue && (pc == LAST_PC) && !WRAP_EN;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = last_issue ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (redirect) state_nxt = ST_FLUSH;
        else if (last_issue) state_nxt = ST_DONE;
      end
      ST_FLUSH: begin
        if (redirect) state_nxt = ST_FLUSH;
        else if (last_issue) state_nxt = ST_DONE;
        else state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (redirect) state_nxt = ST_FLUSH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req_v  <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc    <= redirect_pc;
        req_v <= 1'b0;
      end else begin
        req_v <= issue;
        if (issue) begin
          req_pc <= pc;
          pc     <= pc_advance(pc, LAST_PC, WRAP_EN);
        end
      end
    end
  end

  // The memory word returning while in FLUSH belongs to the pre-redirect stream.
  assign buf_push         = req_v && (state != ST_FLUSH);
  assign buf_clear        = redirect;
  assign push_entry.pc    = req_pc;
  assign push_entry.instr = instruction;

  fetch_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (buf_pop),
    .clear     (buf_clear),
    .count     (buf_count),
    .head      (buf_head),
    .valid     (buf_valid)
  );

  assign head_entry = buf_head;
  assign if_valid   = buf_valid;
  assign if_pc      = head_entry.pc;
  assign if_instr   = head_entry.instr;

`ifdef FETCH_WRAP_EN
  assign halted = 1'b0;
`else
  assign halted = (state == ST_DONE) && !buf_valid && !req_v;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, backpressure, redirect, enable, end of memory, async reset.
`timescale 1ns/1ps

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, redirect_valid, if_ready;
  logic [31:0] redirect_pc, pc, instruction, if_pc, if_instr;
  logic        if_valid, halted;

  logic        e_en, e_redirect_valid, e_if_ready;
  logic [31:0] e_redirect_pc, e_pc, e_instruction, e_if_pc, e_if_instr;
  logic        e_if_valid, e_halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.MEM_DEPTH(1024), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc(pc), .instruction(instruction), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .halted(halted)
  );

  fetch_unit #(.MEM_DEPTH(1024), .RESET_PC(32'd1020)) dut_end (
    .clk(clk), .rst_n(rst_n), .en(e_en), .redirect_valid(e_redirect_valid),
    .redirect_pc(e_redirect_pc), .pc(e_pc), .instruction(e_instruction), .if_valid(e_if_valid),
    .if_ready(e_if_ready), .if_pc(e_if_pc), .if_instr(e_if_instr), .halted(e_halted)
  );

  // Synchronous-read instruction memories holding memory[i] = i*4.
  always @(posedge clk) begin
    instruction   <= {pc[29:0], 2'b00};
    e_instruction <= {e_pc[29:0], 2'b00};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut.buf_push && !dut.buf_pop && dut.buf_count == 2'd2) begin
        failures++;
        $display("FAIL buffer_overflow count=%0d push=1 pop=0 at %0t", dut.buf_count, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    e_en = 1'b0; e_redirect_valid = 1'b0; e_redirect_pc = '0; e_if_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'd0) begin failures++; $display("FAIL reset_if_pc got=%0h exp=0", if_pc); end
    checks++; if (if_instr !== 32'd0) begin failures++; $display("FAIL reset_if_instr got=%0h exp=0", if_instr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (e_pc !== 32'd1020) begin failures++; $display("FAIL reset_end_pc got=%0d exp=1020", e_pc); end
    rst_n = 1'b1;
    step();
    checks++; if (pc !== 32'd0) begin failures++; $display("FAIL idle_pc_hold got=%0d exp=0", pc); end
  endtask

  task automatic test_stream();
    en = 1'b1; if_ready = 1'b1;
    step();
    checks++; if (pc !== 32'd1) begin failures++; $display("FAIL stream_pc0 got=%0d exp=1", pc); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stream_latency got=%b exp=0", if_valid); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== 32'(i * 4) || pc !== 32'(i + 2)) begin
        failures++;
        $display("FAIL stream_%0d got v=%b pc=%0d instr=%0h fpc=%0d exp v=1 pc=%0d instr=%0h fpc=%0d",
                 i, if_valid, if_pc, if_instr, pc, i, i * 4, i + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'd7 || pc !== 32'd9) begin
        failures++;
        $display("FAIL stall_%0d got v=%b pc=%0d fpc=%0d exp v=1 pc=7 fpc=9", i, if_valid, if_pc, pc);
      end
    end
    checks++; if (dut.buf_count !== 2'd2) begin failures++; $display("FAIL stall_fill got=%0d exp=2", dut.buf_count); end
    if_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(7 + j) || if_instr !== 32'((7 + j) * 4) || pc !== 32'(9 + j)) begin
        failures++;
        $display("FAIL release_%0d got v=%b pc=%0d instr=%0h fpc=%0d exp pc=%0d fpc=%0d",
                 j, if_valid, if_pc, if_instr, pc, 7 + j, 9 + j);
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b0;
    step();
    redirect_valid = 1'b0; if_ready = 1'b1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_clear got=%b exp=0", if_valid); end
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL redir_pc got=%0h exp=40", pc); end
    step();
    checks++; if (if_valid !== 1'b0 || pc !== 32'h41) begin failures++; $display("FAIL redir_flush got v=%b fpc=%0h exp v=0 fpc=41", if_valid, pc); end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h100) begin
      failures++;
      $display("FAIL redir_first got v=%b pc=%0h instr=%0h exp v=1 pc=40 instr=100", if_valid, if_pc, if_instr);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(32'h40 + k)) begin
        failures++;
        $display("FAIL redir_seq_%0d got v=%b pc=%0h exp pc=%0h", k, if_valid, if_pc, 32'h40 + k);
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || pc !== 32'h45) begin failures++; $display("FAIL en_drain got v=%b pc=%0h fpc=%0h exp v=1 pc=44 fpc=45", if_valid, if_pc, pc); end
    step();
    checks++; if (if_valid !== 1'b0 || pc !== 32'h45) begin failures++; $display("FAIL en_empty got v=%b fpc=%0h exp v=0 fpc=45", if_valid, pc); end
    en = 1'b1;
    step();
    checks++; if (if_valid !== 1'b0 || pc !== 32'h46) begin failures++; $display("FAIL en_resume got v=%b fpc=%0h exp v=0 fpc=46", if_valid, pc); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h45) begin failures++; $display("FAIL en_first got v=%b pc=%0h exp v=1 pc=45", if_valid, if_pc); end
  endtask

  task automatic test_end_of_memory();
    int v_exp [7];
    int ipc_exp [7];
    int fpc_exp [7];
    int hal_exp [7];
    int tail_v, tail_pc, tail_h, third_fpc;
`ifdef FETCH_WRAP_EN
    v_exp = '{0, 1, 1, 1, 1, 1, 1};
    ipc_exp = '{0, 1020, 1021, 1022, 1023, 0, 1};
    fpc_exp = '{1021, 1022, 1023, 0, 1, 2, 3};
    hal_exp = '{0, 0, 0, 0, 0, 0, 0};
    tail_v = 1; tail_pc = 0; tail_h = 0; third_fpc = 0;
`else
    v_exp = '{0, 1, 1, 1, 1, 0, 0};
    ipc_exp = '{0, 1020, 1021, 1022, 1023, 0, 0};
    fpc_exp = '{1021, 1022, 1023, 1023, 1023, 1023, 1023};
    hal_exp = '{0, 0, 0, 0, 0, 1, 1};
    tail_v = 0; tail_pc = 0; tail_h = 1; third_fpc = 1023;
`endif
    e_en = 1'b1; e_if_ready = 1'b1;
    for (int s = 0; s < 7; s++) begin
      step();
      checks++;
      if (e_if_valid !== 1'(v_exp[s]) || e_pc !== 32'(fpc_exp[s]) || e_halted !== 1'(hal_exp[s]) ||
          (v_exp[s] == 1 && (e_if_pc !== 32'(ipc_exp[s]) || e_if_instr !== 32'(ipc_exp[s] * 4)))) begin
        failures++;
        $display("FAIL eom_%0d got v=%b pc=%0d instr=%0h fpc=%0d h=%b exp v=%0d pc=%0d fpc=%0d h=%0d",
                 s, e_if_valid, e_if_pc, e_if_instr, e_pc, e_halted, v_exp[s], ipc_exp[s], fpc_exp[s], hal_exp[s]);
      end
    end
    e_redirect_valid = 1'b1; e_redirect_pc = 32'd1022;
    step();
    e_redirect_valid = 1'b0;
    checks++; if (e_if_valid !== 1'b0 || e_pc !== 32'd1022 || e_halted !== 1'b0) begin failures++; $display("FAIL eom_redir got v=%b fpc=%0d h=%b exp v=0 fpc=1022 h=0", e_if_valid, e_pc, e_halted); end
    step();
    checks++; if (e_if_valid !== 1'b0 || e_pc !== 32'd1023) begin failures++; $display("FAIL eom_redir_flush got v=%b fpc=%0d exp v=0 fpc=1023", e_if_valid, e_pc); end
    step();
    checks++; if (e_if_valid !== 1'b1 || e_if_pc !== 32'd1022 || e_pc !== 32'(third_fpc)) begin failures++; $display("FAIL eom_redir_first got v=%b pc=%0d fpc=%0d exp v=1 pc=1022 fpc=%0d", e_if_valid, e_if_pc, e_pc, third_fpc); end
    step();
    checks++; if (e_if_valid !== 1'b1 || e_if_pc !== 32'd1023) begin failures++; $display("FAIL eom_redir_last got v=%b pc=%0d exp v=1 pc=1023", e_if_valid, e_if_pc); end
    step();
    checks++;
    if (e_if_valid !== 1'(tail_v) || e_halted !== 1'(tail_h) || (tail_v == 1 && e_if_pc !== 32'(tail_pc))) begin
      failures++;
      $display("FAIL eom_tail got v=%b pc=%0d h=%b exp v=%0d pc=%0d h=%0d", e_if_valid, e_if_pc, e_halted, tail_v, tail_pc, tail_h);
    end
  endtask

  task automatic test_reset_mid();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'd0 || if_valid !== 1'b0 || if_pc !== 32'd0 || halted !== 1'b0) begin failures++; $display("FAIL areset got fpc=%0d v=%b pc=%0d h=%b exp 0 0 0 0", pc, if_valid, if_pc, halted); end
    checks++; if (e_pc !== 32'd1020 || e_if_valid !== 1'b0) begin failures++; $display("FAIL areset_end got fpc=%0d v=%b exp 1020 0", e_pc, e_if_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (pc !== 32'd1 || if_valid !== 1'b0) begin failures++; $display("FAIL restream_issue got fpc=%0d v=%b exp 1 0", pc, if_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== 32'(i * 4)) begin
        failures++;
        $display("FAIL restream_%0d got v=%b pc=%0d instr=%0h exp v=1 pc=%0d instr=%0h", i, if_valid, if_pc, if_instr, i, i * 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_enable();
    test_end_of_memory();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
